// File: rtl/sap1_fetch_unit.sv
// SAP-1 instruction fetch stage: PC/MAR/IR/operand registers and a valid/ready issue port.
// Optional operand fetch for LDA/ADD/SUB is enabled by defining FETCH_OPERAND_EN.
module sap1_fetch_unit #(
  parameter int          ADDR_W = 4,
  parameter int          DATA_W = 8,
  parameter logic [3:0]  HLT_OP = 4'hF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              clr_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  input  logic [DATA_W-1:0] ram_data_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [DATA_W-1:0] operand_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              halt_o
);

`ifdef FETCH_OPERAND_EN
  typedef enum logic [2:0] {
    S_ADDR, S_INSTR, S_OADDR, S_OPND, S_ISSUE, S_HALT
  } state_t;
`else
  typedef enum logic [2:0] {
    S_ADDR, S_INSTR, S_ISSUE, S_HALT
  } state_t;
`endif

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   pc_reg, pc_next;
  logic [ADDR_W-1:0]   mar_reg, mar_next;
  logic [DATA_W-1:0]   ir_reg, ir_next;
  logic [3:0]          opcode;

  assign opcode = ram_data_i[DATA_W-1 -: 4];

`ifdef FETCH_OPERAND_EN
  logic [DATA_W-1:0]   opnd_reg, opnd_next;
  logic                is_mem_ref;
  assign is_mem_ref = (opcode < 4'd3);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= S_ADDR;
      pc_reg    <= '0;
      mar_reg   <= '0;
      ir_reg    <= '0;
`ifdef FETCH_OPERAND_EN
      opnd_reg  <= '0;
`endif
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      mar_reg   <= mar_next;
      ir_reg    <= ir_next;
`ifdef FETCH_OPERAND_EN
      opnd_reg  <= opnd_next;
`endif
    end
  end

  // clr_i overrides the enable and every transition, including a pending issue.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    mar_next   = mar_reg;
    ir_next    = ir_reg;
`ifdef FETCH_OPERAND_EN
    opnd_next  = opnd_reg;
`endif
    if (clr_i) begin
      state_next = S_ADDR;
      pc_next    = '0;
      mar_next   = '0;
      ir_next    = '0;
`ifdef FETCH_OPERAND_EN
      opnd_next  = '0;
`endif
    end else if (en_i) begin
      case (state_reg)
        S_ADDR: begin
          mar_next   = pc_reg;
          state_next = S_INSTR;
        end
        S_INSTR: begin
          ir_next = ram_data_i;
          pc_next = pc_reg + ADDR_W'(1);
          if (opcode == HLT_OP) begin
            state_next = S_HALT;
`ifdef FETCH_OPERAND_EN
          end else if (is_mem_ref) begin
            state_next = S_OADDR;
`endif
          end else begin
`ifdef FETCH_OPERAND_EN
            opnd_next  = '0;
`endif
            state_next = S_ISSUE;
          end
        end
`ifdef FETCH_OPERAND_EN
        S_OADDR: begin
          mar_next   = ir_reg[ADDR_W-1:0];
          state_next = S_OPND;
        end
        S_OPND: begin
          opnd_next  = ram_data_i;
          state_next = S_ISSUE;
        end
`endif
        S_ISSUE: begin
          if (ready_i) state_next = S_ADDR;
        end
        S_HALT: state_next = S_HALT;
        default: state_next = S_ADDR;
      endcase
    end
  end

  assign ram_addr_o = mar_reg;
  assign instr_o    = ir_reg;
  assign pc_o       = pc_reg;
  assign valid_o    = (state_reg == S_ISSUE);
  assign halt_o     = (state_reg == S_HALT);
`ifdef FETCH_OPERAND_EN
  assign operand_o  = opnd_reg;
`else
  assign operand_o  = '0;
`endif

endmodule

// File: tb/tb_sap1_fetch_unit.sv
// Self-checking bench for sap1_fetch_unit: directed programs plus randomized
// enable/ready traffic, compared against a program-walking reference model.
module tb_sap1_fetch_unit;

`ifdef FETCH_OPERAND_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_ni, en_i, clr_i, ready_i;
  logic [3:0] ram_addr_o, pc_o;
  logic [7:0] ram_data_i, instr_o, operand_o;
  logic       valid_o, halt_o;

  logic [7:0] mem [16];
  logic [3:0] m_pc;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk_i = ~clk_i;
  assign ram_data_i = mem[ram_addr_o];

  sap1_fetch_unit dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (en_i),
    .clr_i      (clr_i),
    .ram_addr_o (ram_addr_o),
    .ram_data_i (ram_data_i),
    .instr_o    (instr_o),
    .operand_o  (operand_o),
    .pc_o       (pc_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .halt_o     (halt_o)
  );

  task automatic chk(input string tag, input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s/%s: observed 0x%0h expected 0x%0h", tag, name, obs, exp);
    end
  endtask

  task automatic load_program();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0] = 8'h09; mem[1] = 8'h1A; mem[2] = 8'h1B; mem[3] = 8'h2C;
    mem[4] = 8'hE0; mem[5] = 8'hF0;
    mem[9] = 8'h01; mem[10] = 8'h02; mem[11] = 8'h03; mem[12] = 8'h04;
  endtask

  task automatic check_zero(input string tag);
    chk(tag, "valid", valid_o, 0);
    chk(tag, "halt", halt_o, 0);
    chk(tag, "pc", pc_o, 0);
    chk(tag, "addr", ram_addr_o, 0);
    chk(tag, "instr", instr_o, 0);
    chk(tag, "operand", operand_o, 0);
  endtask

  task automatic do_clear(input string tag);
    clr_i = 1'b1;
    en_i  = 1'($urandom_range(0, 1));
    @(posedge clk_i); #1;
    clr_i = 1'b0;
    check_zero(tag);
    m_pc = 4'd0;
  endtask

  // en_mode: 0 always, 1 alternate, 2 random.  rdy_mode: 0 always, 1 random, 2 hold low 7 cycles on first issue.
  task automatic run_seq(input string tag, input int max_iss, input int en_mode, input int rdy_mode);
    logic [7:0] ei[$];
    logic [7:0] eo[$];
    int         el[$];
    logic [3:0] p, sp1;
    bit         exp_halt, seen, v, e, r, phase, done;
    int         n_exp, got, cnt, hold, budget;
    p = m_pc;
    sp1 = m_pc + 4'd1;
    exp_halt = 1'b0;
    while (ei.size() < max_iss) begin
      logic [7:0] ins;
      ins = mem[p];
      p = p + 4'd1;
      if (ins[7:4] == 4'hF) begin
        exp_halt = 1'b1;
        break;
      end
      ei.push_back(ins);
      if (FEAT && ins[7:4] < 4'd3) begin
        eo.push_back(mem[ins[3:0]]);
        el.push_back(4);
      end else begin
        eo.push_back(8'h00);
        el.push_back(2);
      end
    end
    n_exp = ei.size();
    got = 0; cnt = 0; hold = 0; seen = 1'b0; phase = 1'b0; done = 1'b0;
    for (budget = 0; budget < 3000 && !done; budget++) begin
      if (halt_o) begin
        chk(tag, "halt_expected", 32'(exp_halt), 1);
        chk(tag, "issues_before_halt", got, n_exp);
        chk(tag, "halt_latency", cnt, 2);
        chk(tag, "pc_at_halt", pc_o, p);
        for (int k = 0; k < 5; k++) begin
          chk(tag, "valid_after_halt", valid_o, 0);
          chk(tag, "halt_sticky", halt_o, 1);
          en_i = 1'b1; ready_i = 1'b1;
          @(posedge clk_i); #1;
        end
        done = 1'b1;
      end else if (got == n_exp && !exp_halt) begin
        chk(tag, "pc_end", pc_o, p);
        done = 1'b1;
      end else begin
        if (valid_o) begin
          if (got >= n_exp) begin
            chk(tag, "unexpected_issue", valid_o, 0);
          end else begin
            if (!seen) chk(tag, "latency", cnt, el[got]);
            seen = 1'b1;
            chk(tag, "instr", instr_o, ei[got]);
            chk(tag, "operand", operand_o, eo[got]);
          end
        end
        phase = ~phase;
        case (en_mode)
          0:       e = 1'b1;
          1:       e = phase;
          default: e = ($urandom_range(0, 3) != 0);
        endcase
        case (rdy_mode)
          0: r = 1'b1;
          1: r = 1'($urandom_range(0, 1));
          default: begin
            if (valid_o && got == 0 && hold < 7) begin
              r = 1'b0;
              hold++;
              chk(tag, "pc_during_hold", pc_o, sp1);
            end else begin
              r = 1'b1;
            end
          end
        endcase
        v = valid_o;
        en_i = e; ready_i = r;
        @(posedge clk_i); #1;
        if (e) begin
          if (v && r) begin
            $display("%s: issue %0d instr=0x%02h operand=0x%02h", tag, got, ei[got], eo[got]);
            got++; seen = 1'b0; cnt = 0;
          end else if (!v) begin
            cnt++;
          end
        end
      end
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL %s/timeout: observed %0d issues expected %0d", tag, got, n_exp);
    end
    m_pc = p;
  endtask

  initial begin
    rst_ni = 1'b0; en_i = 1'b0; clr_i = 1'b0; ready_i = 1'b0;
    load_program();
    repeat (2) @(posedge clk_i);
    #1;
    check_zero("reset");
    rst_ni = 1'b1;
    m_pc = 4'd0;

    run_seq("program", 16, 0, 0);
    do_clear("clr_in_halt");
    run_seq("backpressure", 16, 0, 2);
    do_clear("clr2");
    run_seq("en_toggle", 16, 1, 0);
    do_clear("clr3");

    // Async reset in the middle of a memory-reference fetch.
    en_i = 1'b1; ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("mid_reset", "pc_before", pc_o, 1);
    chk("mid_reset", "instr_before", instr_o, 8'h09);
    #2 rst_ni = 1'b0;
    #1 check_zero("async_reset");
    @(posedge clk_i); #1;
    check_zero("reset_held");
    rst_ni = 1'b1;
    m_pc = 4'd0;

    for (int i = 0; i < 16; i++) mem[i] = 8'hE0;
    mem[15] = 8'hE5;
    run_seq("wrap", 16, 0, 0);

    for (int round = 0; round < 4; round++) begin
      do_clear("clr_rand");
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
      run_seq("random", 12, 2, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
